argon_alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the Argon single-bus ALU.
- Keeps the command-driven latch/compute/output model and the single-cycle opcode set.
- Widens the datapath to WIDTH and adds iterative unsigned multiply (MUL) and divide (DIV), which produce a double result (Y, Y2).
- Sits on the CPU data bus alongside the register file; the sequencer polls o_busy or waits for o_done.

---
 rtl/argon_alu_mc_pkg.sv | 59 +++++
 rtl/argon_alu_mc_if.sv | 25 ++
 rtl/argon_muldiv_iter.sv | 83 ++++++++
 rtl/argon_alu_mc.sv | 208 ++++++++++++++++++++
 tb/tb_argon_alu_mc.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/argon_alu_mc_pkg.sv
// Shared definitions for the multi-cycle Argon ALU: bus commands, opcodes,
// flag bit positions and controller states.
package argon_alu_mc_pkg;

    // Codes 8..14 are unused and behave like NOP
    typedef enum logic [3:0] {
        LATCHA   = 4'd0,
        LATCHB   = 4'd1,
        LATCHF   = 4'd2,
        LATCHOP  = 4'd3,
        COMPUTE  = 4'd4,
        OUTPUTY  = 4'd5,
        OUTPUTY2 = 4'd6,
        OUTPUTF  = 4'd7,
        NOP      = 4'd15
    } cmd_e;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADC   = 5'd1,
        OP_SBB   = 5'd2,
        OP_CMP   = 5'd3,
        OP_INC   = 5'd4,
        OP_DEC   = 5'd5,
        OP_NAND  = 5'd6,
        OP_AND   = 5'd7,
        OP_OR    = 5'd8,
        OP_NOR   = 5'd9,
        OP_XOR   = 5'd10,
        OP_LSH   = 5'd11,
        OP_RSH   = 5'd12,
        OP_ROL   = 5'd13,
        OP_ROR   = 5'd14,
        OP_RSV15 = 5'd15,
        OP_MUL   = 5'd16,
        OP_DIV   = 5'd17
    } op_e;

    localparam int F_CARRY    = 0;
    localparam int F_ZERO     = 1;
    localparam int F_BORROW   = 2;
    localparam int F_EQUAL    = 3;
    localparam int F_GREATER  = 4;
    localparam int F_LESS     = 5;
    localparam int F_OVERFLOW = 6;
    localparam int F_ERROR    = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [7:0] flag_bit(input int idx);
        flag_bit = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/argon_alu_mc_if.sv
// Bus-side signal bundle of the Argon ALU; the sequencer is master.
interface argon_alu_mc_if #(
    parameter int WIDTH = 16
);
    import argon_alu_mc_pkg::*;

    cmd_e               i_command;
    logic               i_valid;
    logic [WIDTH-1:0]   i_data;
    logic [WIDTH-1:0]   o_data;
    logic               o_valid;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_command, i_valid, i_data,
        input  o_data, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_command, i_valid, i_data,
        output o_data, o_valid, o_busy, o_done
    );

endinterface

// File: rtl/argon_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// done flags the final iteration; hi/lo carry that iteration's result combinationally.
module argon_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             start,
    input  logic             op,      // 0 = multiply, 1 = divide
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             busy_reg;
    logic             op_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    // Independent of start so the controller can branch on it without a loop
    assign dbz = op & (b == '0);

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
        if (op_reg) begin
            hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_step = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // Multiply: hi accumulates, lo holds the multiplier. Divide: hi is the
    // partial remainder, lo shifts the dividend out and the quotient in.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            busy_reg <= 1'b0;
            op_reg   <= 1'b0;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            opnd_reg <= '0;
        end else if (start && !busy_reg && !dbz) begin
            busy_reg <= 1'b1;
            op_reg   <= op;
            cnt_reg  <= CW'(WIDTH);
            hi_reg   <= '0;
            lo_reg   <= op ? a : b;
            opnd_reg <= op ? b : a;
        end else if (busy_reg) begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == CW'(1));
    assign hi   = hi_step;
    assign lo   = lo_step;

endmodule

// File: rtl/argon_alu_mc.sv
// Multi-cycle Argon ALU: command-driven latch/compute/output on the CPU data bus,
// single-cycle opcodes computed here, MUL/DIV delegated to the iteration engine.
module argon_alu_mc
    import argon_alu_mc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    argon_alu_mc_if.slave  bus
);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] ra_reg, ra_next;
    logic [WIDTH-1:0] rb_reg, rb_next;
    logic [WIDTH-1:0] ry_reg, ry_next;
    logic [WIDTH-1:0] ry2_reg, ry2_next;
    logic [7:0]       rf_reg, rf_next;
    logic [4:0]       rop_reg, rop_next;

    logic             eng_start;
    logic             eng_op;
    logic             eng_busy;
    logic             eng_done;
    logic             eng_dbz;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_y;
    logic [7:0]       alu_f;
    logic             alu_wr_y;
    logic [SHW-1:0]   sh_amt;
    logic             is_muldiv;

    assign sh_amt    = rb_reg[SHW-1:0];
    assign eng_op    = (rop_reg == OP_DIV);
    assign is_muldiv = (rop_reg == OP_MUL) || (rop_reg == OP_DIV);

    argon_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .start   (eng_start),
        .op      (eng_op),
        .a       (ra_reg),
        .b       (rb_reg),
        .busy    (eng_busy),
        .done    (eng_done),
        .hi      (eng_hi),
        .lo      (eng_lo),
        .dbz     (eng_dbz)
    );

    // Single-cycle datapath; subtractions borrow out through the extra top bit
    always_comb begin
        sum_ext  = '0;
        alu_y    = ry_reg;
        alu_f    = '0;
        alu_wr_y = 1'b1;
        case (op_e'(rop_reg))
            OP_ADD: begin
                sum_ext         = {1'b0, ra_reg} + {1'b0, rb_reg};
                alu_y           = sum_ext[WIDTH-1:0];
                alu_f[F_CARRY]  = sum_ext[WIDTH];
            end
            OP_ADC: begin
                sum_ext         = {1'b0, ra_reg} + {1'b0, rb_reg} + {{WIDTH{1'b0}}, rf_reg[F_CARRY]};
                alu_y           = sum_ext[WIDTH-1:0];
                alu_f[F_CARRY]  = sum_ext[WIDTH];
            end
            OP_SBB: begin
                sum_ext         = {1'b0, ra_reg} - {1'b0, rb_reg} - {{WIDTH{1'b0}}, rf_reg[F_BORROW]};
                alu_y           = sum_ext[WIDTH-1:0];
                alu_f[F_BORROW] = sum_ext[WIDTH];
            end
            OP_CMP: begin
                alu_wr_y         = 1'b0;
                alu_f[F_EQUAL]   = (ra_reg == rb_reg);
                alu_f[F_GREATER] = (ra_reg > rb_reg);
                alu_f[F_LESS]    = (ra_reg < rb_reg);
            end
            OP_INC: begin
                sum_ext         = {1'b0, ra_reg} + (WIDTH+1)'(1);
                alu_y           = sum_ext[WIDTH-1:0];
                alu_f[F_CARRY]  = sum_ext[WIDTH];
            end
            OP_DEC: begin
                sum_ext         = {1'b0, ra_reg} - (WIDTH+1)'(1);
                alu_y           = sum_ext[WIDTH-1:0];
                alu_f[F_BORROW] = sum_ext[WIDTH];
            end
            OP_NAND: alu_y = ~(ra_reg & rb_reg);
            OP_AND:  alu_y = ra_reg & rb_reg;
            OP_OR:   alu_y = ra_reg | rb_reg;
            OP_NOR:  alu_y = ~(ra_reg | rb_reg);
            OP_XOR:  alu_y = ra_reg ^ rb_reg;
            OP_LSH:  alu_y = ra_reg << sh_amt;
            OP_RSH:  alu_y = ra_reg >> sh_amt;
            // A shift by WIDTH yields zero, so rotate-by-0 returns rA
            OP_ROL:  alu_y = (ra_reg << sh_amt) | (ra_reg >> (WIDTH - int'(sh_amt)));
            OP_ROR:  alu_y = (ra_reg >> sh_amt) | (ra_reg << (WIDTH - int'(sh_amt)));
            default: begin
                alu_wr_y = 1'b0;
                alu_f    = flag_bit(F_ERROR);
            end
        endcase
        if (alu_wr_y) begin
            alu_f[F_ZERO] = (alu_y == '0);
        end
    end

    always_comb begin
        state_next = state_reg;
        ra_next    = ra_reg;
        rb_next    = rb_reg;
        ry_next    = ry_reg;
        ry2_next   = ry2_reg;
        rf_next    = rf_reg;
        rop_next   = rop_reg;
        eng_start  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                case (bus.i_command)
                    LATCHA:  if (bus.i_valid) ra_next  = bus.i_data;
                    LATCHB:  if (bus.i_valid) rb_next  = bus.i_data;
                    LATCHF:  if (bus.i_valid) rf_next  = bus.i_data[7:0];
                    LATCHOP: if (bus.i_valid) rop_next = bus.i_data[4:0];
                    COMPUTE: begin
                        if (is_muldiv) begin
                            eng_start = 1'b1;
                            if (eng_dbz) begin
                                ry_next    = '1;
                                ry2_next   = ra_reg;
                                rf_next    = flag_bit(F_ERROR);
                                state_next = S_DONE;
                            end else begin
                                state_next = eng_op ? S_DIV : S_MUL;
                            end
                        end else begin
                            ry_next    = alu_y;
                            rf_next    = alu_f;
                            state_next = S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
            S_MUL: begin
                if (eng_done) begin
                    ry_next             = eng_lo;
                    ry2_next            = eng_hi;
                    rf_next             = '0;
                    rf_next[F_OVERFLOW] = (eng_hi != '0);
                    rf_next[F_ZERO]     = ({eng_hi, eng_lo} == '0);
                    state_next          = S_DONE;
                end
            end
            S_DIV: begin
                if (eng_done) begin
                    ry_next         = eng_lo;
                    ry2_next        = eng_hi;
                    rf_next         = '0;
                    rf_next[F_ZERO] = (eng_lo == '0);
                    state_next      = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg <= S_IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            ry_reg    <= '0;
            ry2_reg   <= '0;
            rf_reg    <= '0;
            rop_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ra_reg    <= ra_next;
            rb_reg    <= rb_next;
            ry_reg    <= ry_next;
            ry2_reg   <= ry2_next;
            rf_reg    <= rf_next;
            rop_reg   <= rop_next;
        end
    end

    always_comb begin
        bus.o_data  = '0;
        bus.o_valid = 1'b0;
        if (state_reg == S_IDLE) begin
            case (bus.i_command)
                OUTPUTY:  begin bus.o_data = ry_reg;  bus.o_valid = 1'b1; end
                OUTPUTY2: begin bus.o_data = ry2_reg; bus.o_valid = 1'b1; end
                OUTPUTF:  begin bus.o_data = {{(WIDTH-8){1'b0}}, rf_reg}; bus.o_valid = 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus.o_busy = eng_busy;
    assign bus.o_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_argon_alu_mc.sv
// Randomised and directed bench for argon_alu_mc against an arithmetic reference model.
module tb_argon_alu_mc;
    import argon_alu_mc_pkg::*;

    localparam int          W    = 16;
    localparam int unsigned MASK = 32'hFFFF;

    logic clk = 1'b0;
    logic rst;

    argon_alu_mc_if #(.WIDTH(W)) bus();

    argon_alu_mc #(.WIDTH(W)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Architectural state as the sequencer sees it
    int unsigned m_a, m_b, m_y, m_y2, m_f, m_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(output int unsigned y, output int unsigned y2,
                                  output int unsigned f, output int unsigned lat);
        int unsigned a, b, s, r, p;
        int          d;
        a = m_a; b = m_b; s = m_b % 16;
        y = m_y; y2 = m_y2; f = 0; lat = 1;
        case (m_op)
            0:  begin r = a + b; y = r & MASK; if (r > MASK) f |= 1; end
            1:  begin r = a + b + (m_f & 1); y = r & MASK; if (r > MASK) f |= 1; end
            2:  begin d = int'(a) - int'(b) - int'((m_f >> 2) & 1); y = unsigned'(d) & MASK; if (d < 0) f |= 4; end
            3:  begin if (a == b) f |= 8; if (a > b) f |= 16; if (a < b) f |= 32; end
            4:  begin r = a + 1; y = r & MASK; if (r > MASK) f |= 1; end
            5:  begin y = (a - 1) & MASK; if (a == 0) f |= 4; end
            6:  y = ~(a & b) & MASK;
            7:  y = a & b;
            8:  y = a | b;
            9:  y = ~(a | b) & MASK;
            10: y = a ^ b;
            11: y = (a << s) & MASK;
            12: y = a >> s;
            13: y = ((a << s) | (a >> (16 - s))) & MASK;
            14: y = ((a >> s) | (a << (16 - s))) & MASK;
            16: begin
                p = a * b; y = p & MASK; y2 = p >> 16; lat = 17;
                if (y2 != 0) f |= 64;
                if (p == 0) f |= 2;
            end
            17: begin
                if (b == 0) begin y = MASK; y2 = a; f = 128; end
                else begin y = a / b; y2 = a % b; lat = 17; if (y == 0) f |= 2; end
            end
            default: f = 128;
        endcase
        if (m_op <= 14 && m_op != 3 && y == 0) f |= 2;
    endfunction

    task automatic latch(input cmd_e c, input int unsigned d, input bit v);
        bus.i_command = c;
        bus.i_data    = d[15:0];
        bus.i_valid   = v;
        @(posedge clk); #1;
        bus.i_command = NOP;
        bus.i_valid   = 1'b0;
        if (v) begin
            case (c)
                LATCHA:  m_a  = d & MASK;
                LATCHB:  m_b  = d & MASK;
                LATCHF:  m_f  = d & 255;
                LATCHOP: m_op = d & 31;
                default: ;
            endcase
        end
    endtask

    task automatic read_reg(input cmd_e c, output logic [15:0] d, output logic v);
        bus.i_command = c;
        #1;
        d = bus.o_data;
        v = bus.o_valid;
        bus.i_command = NOP;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus.o_done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] d;
        logic        v;
        read_reg(OUTPUTY, d, v);  check({tag, "_y"}, d, m_y);
        read_reg(OUTPUTY2, d, v); check({tag, "_y2"}, d, m_y2);
        read_reg(OUTPUTF, d, v);  check({tag, "_f"}, {v, d}, {1'b1, 16'(m_f)});
    endtask

    task automatic run_compute(input bit poke_done);
        int unsigned ey, ey2, ef, elat;
        int          lat;
        model(ey, ey2, ef, elat);
        bus.i_command = COMPUTE;
        @(posedge clk); #1;
        bus.i_command = NOP;
        check("busy", 32'(bus.o_busy), 32'(elat > 1));
        wait_done(1, lat);
        check("latency", lat, elat);
        if (poke_done) bus.i_command = COMPUTE;
        @(posedge clk); #1;
        bus.i_command = NOP;
        check("done_pulse", {bus.o_done, bus.o_busy}, 0);
        m_y = ey; m_y2 = ey2; m_f = ef;
        $display("op=%0d a=%04h b=%04h -> y=%04h y2=%04h f=%02h lat=%0d", m_op, m_a, m_b, ey, ey2, ef, lat);
        check_regs("res");
    endtask

    task automatic load(input int unsigned a, input int unsigned b, input int unsigned op);
        latch(LATCHA, a, 1'b1);
        latch(LATCHB, b, 1'b1);
        latch(LATCHOP, op, 1'b1);
    endtask

    initial begin
        logic [15:0]  d;
        logic         v;
        int           lat;
        int unsigned  ey, ey2, ef, elat;

        bus.i_command = NOP;
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
        rst = 1'b1;
        m_a = 0; m_b = 0; m_y = 0; m_y2 = 0; m_f = 0; m_op = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_flags", {bus.o_busy, bus.o_done}, 0);
        check_regs("rst");

        // MUL with overflow into Y2
        load(32'h1234, 32'h0100, 16);
        run_compute(1'b0);

        // DIV then divide-by-zero
        load(100, 7, 17);
        run_compute(1'b0);
        latch(LATCHB, 0, 1'b1);
        run_compute(1'b0);

        // ADC with carry-in wrapping to zero
        load(32'hFFFF, 0, 1);
        latch(LATCHF, 1, 1'b1);
        run_compute(1'b0);

        // Unqualified latch must be ignored
        latch(LATCHA, 32'hBEEF, 1'b0);
        latch(LATCHOP, 0, 1'b1);
        run_compute(1'b0);

        // Bus lockout while MUL iterates
        load(32'h00FF, 3, 16);
        model(ey, ey2, ef, elat);
        bus.i_command = COMPUTE;
        @(posedge clk); #1;
        bus.i_command = LATCHA; bus.i_data = 16'h5555; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        read_reg(OUTPUTY, d, v);
        check("lock_y", {v, d}, 0);
        read_reg(OUTPUTF, d, v);
        check("lock_f", {v, d}, 0);
        wait_done(2, lat);
        check("lock_done", lat, elat);
        @(posedge clk); #1;
        m_y = ey; m_y2 = ey2; m_f = ef;
        check_regs("lock");
        latch(LATCHOP, 0, 1'b1);
        run_compute(1'b0);

        // Rotate by 0 and 1, then an undefined opcode; COMPUTE poked in DONE
        load(32'h8001, 0, 13);
        run_compute(1'b1);
        latch(LATCHB, 1, 1'b1);
        run_compute(1'b0);
        latch(LATCHOP, 20, 1'b1);
        run_compute(1'b1);

        // Reset during iteration 8 of a MUL
        load(32'h1234, 32'h0100, 16);
        bus.i_command = COMPUTE;
        @(posedge clk); #1;
        bus.i_command = NOP;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        m_a = 0; m_b = 0; m_y = 0; m_y2 = 0; m_f = 0; m_op = 0;
        check("rst_mid_flags", {bus.o_busy, bus.o_done, bus.o_valid, bus.o_data}, 0);
        check_regs("rst_mid");
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_mid_nodone", {bus.o_busy, bus.o_done}, 0);
        end
        rst = 1'b0;
        load(3, 5, 16);
        run_compute(1'b0);

        // Randomised transactions
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            op = $urandom_range(0, 31);
            if (op == 15) op = 16;
            latch(LATCHA, $urandom & MASK, $urandom_range(0, 9) != 0);
            latch(LATCHB, ($urandom_range(0, 5) == 0) ? 0 : ($urandom & MASK), $urandom_range(0, 9) != 0);
            latch(LATCHF, $urandom & 255, $urandom_range(0, 9) != 0);
            latch(LATCHOP, op, $urandom_range(0, 9) != 0);
            run_compute(1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
